// File: rtl/arb_req_agent_if.sv
// rtl/arb_req_agent_if.sv - client/arbiter signal bundle for arb_req_agent
//
// Purpose: groups the push/full/pending client side and the request/grant
// arbiter side of one arb_req_agent instance into a single port.
//
// Signals:
//   push      [2:0]        client i enqueues one transaction this cycle
//   full      [2:0]        client i pending count is at DEPTH
//   pend      [3*CNT_W-1:0] packed pending counts, client i at [i*CNT_W +: CNT_W]
//   request   [2:0]        per-client request toward the arbiter
//   grant     [2:0]        encoded grant from the arbiter (0 none, 1..3 client, 1xx illegal)
//   done      [2:0]        one-cycle completion pulse per accepted grant
//   grant_err              sticky protocol-error flag
//
// Modports:
//   master - the clients/arbiter side that drives push and grant
//   slave  - the agent itself
interface arb_req_agent_if #(
  parameter int CNT_W = 3
);

  logic [2:0]         push;
  logic [2:0]         full;
  logic [3*CNT_W-1:0] pend;
  logic [2:0]         request;
  logic [2:0]         grant;
  logic [2:0]         done;
  logic               grant_err;

  modport master (
    output push,
    output grant,
    input  full,
    input  pend,
    input  request,
    input  done,
    input  grant_err
  );

  modport slave (
    input  push,
    input  grant,
    output full,
    output pend,
    output request,
    output done,
    output grant_err
  );

endinterface

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - requester-side agent for a 3-way encoded-grant arbiter
//
// Purpose: keeps a pending-transaction count per client (three clients),
// raises request[i] while client i has work, decodes the arbiter's encoded
// grant into one-hot registered done pulses and flags illegal grants.
//
// Parameters:
//   DEPTH  maximum pending transactions per client (1..7)
//   CNT_W  width of each pending counter, 2**CNT_W > DEPTH
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   arb_req_agent_if.slave (push, full, pend, request, grant, done, grant_err)
//
// Build option:
//   ARB_REQ_GAP_EN  when defined, every accepted grant sends the client through
//                   a one-cycle GAP state so request drops for exactly one
//                   cycle per transaction. When undefined, request stays high
//                   while the count is non-zero.
module arb_req_agent #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  arb_req_agent_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Grant decode shared by all clients.
  logic [2:0]         grant_sel;    // one-hot client addressed by a legal encoding
  logic               grant_illegal;
  logic [2:0]         in_req;       // client FSM currently in REQ
  logic [2:0]         valid_grant;  // grant addressed to a client that is in REQ
  logic               grant_bad;

  // Per-client outputs gathered before driving the interface.
  logic [2:0]         request_w;
  logic [2:0]         full_w;
  logic [3*CNT_W-1:0] pend_w;

  logic [2:0]         done_q;
  logic               grant_err_q;

  always_comb begin
    grant_sel     = 3'b000;
    grant_illegal = bus.grant[2];
    if (!bus.grant[2]) begin
      case (bus.grant[1:0])
        2'd1:    grant_sel = 3'b001;
        2'd2:    grant_sel = 3'b010;
        2'd3:    grant_sel = 3'b100;
        default: grant_sel = 3'b000;
      endcase
    end
  end

  // A grant to a client outside REQ is an error and must not touch that
  // client's count, state or done; masking with in_req gives exactly that.
  assign valid_grant = grant_sel & in_req;
  assign grant_bad   = grant_illegal | (|(grant_sel & ~in_req));

  for (genvar i = 0; i < 3; i++) begin : g_client
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             push_ok;

    // Acceptance looks only at the pre-edge count, so a push while full is
    // dropped even when a grant frees a slot on the same edge.
    assign push_ok = bus.push[i] && (cnt_q < DEPTH_C);

    // REQ implies cnt_q >= 1, so the subtraction cannot wrap.
    assign cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(valid_grant[i]);

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: begin
          if (push_ok) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (valid_grant[i]) begin
`ifdef ARB_REQ_GAP_EN
            state_d = GAP;
`else
            state_d = (cnt_d != '0) ? REQ : IDLE;
`endif
          end
        end
        GAP: begin
          state_d = (cnt_d != '0) ? REQ : IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign in_req[i]                  = (state_q == REQ);
    assign request_w[i]               = (state_q == REQ);
    assign full_w[i]                  = (cnt_q == DEPTH_C);
    assign pend_w[i*CNT_W +: CNT_W]   = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= 3'b000;
      grant_err_q <= 1'b0;
    end else begin
      done_q <= valid_grant;
      if (grant_bad) begin
        grant_err_q <= 1'b1;
      end
    end
  end

  assign bus.request   = request_w;
  assign bus.full      = full_w;
  assign bus.pend      = pend_w;
  assign bus.done      = done_q;
  assign bus.grant_err = grant_err_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// tb/tb_arb_req_agent.sv - directed self-checking bench for arb_req_agent
module tb_arb_req_agent;

  localparam int CNT_W = 3;
  localparam int DEPTH = 4;
`ifdef ARB_REQ_GAP_EN
  localparam bit GAP_BUILD = 1'b1;
`else
  localparam bit GAP_BUILD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  arb_req_agent_if #(.CNT_W(CNT_W)) bus ();

  arb_req_agent #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.push  = 3'b000;
    bus.grant = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.push  = 3'b000;
    bus.grant = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_checks++;
      if (bus.request !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_request cycle %0d: got %b expected 000", c, bus.request);
      end
      n_checks++;
      if (bus.done !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_done cycle %0d: got %b expected 000", c, bus.done);
      end
      n_checks++;
      if (bus.pend !== 9'd0) begin
        n_fail++;
        $display("FAIL reset_pend cycle %0d: got %h expected 0", c, bus.pend);
      end
      n_checks++;
      if (bus.grant_err !== 1'b0 || bus.full !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_err_full cycle %0d: got err=%b full=%b expected 0/000",
                 c, bus.grant_err, bus.full);
      end
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.push = 3'b001;
    tick();
    bus.push = 3'b000;
    n_checks++;
    if (bus.request !== 3'b001 || bus.pend[2:0] !== 3'd1) begin
      n_fail++;
      $display("FAIL single_after_push: got req=%b pend0=%0d expected 001/1",
               bus.request, bus.pend[2:0]);
    end
    tick();
    n_checks++;
    if (bus.request !== 3'b001 || bus.done !== 3'b000) begin
      n_fail++;
      $display("FAIL single_hold: got req=%b done=%b expected 001/000", bus.request, bus.done);
    end
    bus.grant = 3'b001;
    tick();
    bus.grant = 3'b000;
    n_checks++;
    if (bus.done !== 3'b001 || bus.pend[2:0] !== 3'd0 || bus.request !== 3'b000) begin
      n_fail++;
      $display("FAIL single_grant: got done=%b pend0=%0d req=%b expected 001/0/000",
               bus.done, bus.pend[2:0], bus.request);
    end
    tick();
    n_checks++;
    if (bus.done !== 3'b000 || bus.request !== 3'b000 || bus.grant_err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got done=%b req=%b err=%b expected 000/000/0",
               bus.done, bus.request, bus.grant_err);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.push = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (bus.pend[5:3] !== CNT_W'((k < DEPTH) ? k : DEPTH)) begin
        n_fail++;
        $display("FAIL overflow_pend push %0d: got %0d expected %0d",
                 k, bus.pend[5:3], (k < DEPTH) ? k : DEPTH);
      end
    end
    n_checks++;
    if (bus.full !== 3'b010) begin
      n_fail++;
      $display("FAIL overflow_full: got %b expected 010", bus.full);
    end
    // Push held while full and granted: the push is still dropped.
    bus.grant = 3'b010;
    tick();
    bus.push  = 3'b000;
    bus.grant = 3'b000;
    n_checks++;
    if (bus.pend[5:3] !== 3'd3 || bus.done !== 3'b010 || bus.full !== 3'b000) begin
      n_fail++;
      $display("FAIL overflow_grant: got pend1=%0d done=%b full=%b expected 3/010/000",
               bus.pend[5:3], bus.done, bus.full);
    end
    n_checks++;
    if (bus.request !== (GAP_BUILD ? 3'b000 : 3'b010)) begin
      n_fail++;
      $display("FAIL overflow_req_gap: got %b expected %b",
               bus.request, GAP_BUILD ? 3'b000 : 3'b010);
    end
    tick();
    n_checks++;
    if (bus.request !== 3'b010 || bus.done !== 3'b000 || bus.pend[5:3] !== 3'd3) begin
      n_fail++;
      $display("FAIL overflow_recover: got req=%b done=%b pend1=%0d expected 010/000/3",
               bus.request, bus.done, bus.pend[5:3]);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.push = 3'b100;
    tick();
    tick();
    n_checks++;
    if (bus.pend[8:6] !== 3'd2) begin
      n_fail++;
      $display("FAIL simul_setup: got pend2=%0d expected 2", bus.pend[8:6]);
    end
    bus.grant = 3'b011;
    tick();
    bus.push  = 3'b000;
    bus.grant = 3'b000;
    n_checks++;
    if (bus.pend[8:6] !== 3'd2 || bus.done !== 3'b100) begin
      n_fail++;
      $display("FAIL simul_count: got pend2=%0d done=%b expected 2/100",
               bus.pend[8:6], bus.done);
    end
    n_checks++;
    if (bus.request !== (GAP_BUILD ? 3'b000 : 3'b100)) begin
      n_fail++;
      $display("FAIL simul_req: got %b expected %b",
               bus.request, GAP_BUILD ? 3'b000 : 3'b100);
    end
    tick();
    n_checks++;
    if (bus.request !== 3'b100 || bus.done !== 3'b000 || bus.pend[8:6] !== 3'd2) begin
      n_fail++;
      $display("FAIL simul_after: got req=%b done=%b pend2=%0d expected 100/000/2",
               bus.request, bus.done, bus.pend[8:6]);
    end
  endtask

  task automatic test_errors();
    do_reset();
    bus.push = 3'b001;
    tick();
    bus.push  = 3'b000;
    bus.grant = 3'b101;
    tick();
    bus.grant = 3'b000;
    n_checks++;
    if (bus.grant_err !== 1'b1 || bus.pend[2:0] !== 3'd1 || bus.done !== 3'b000) begin
      n_fail++;
      $display("FAIL err_illegal: got err=%b pend0=%0d done=%b expected 1/1/000",
               bus.grant_err, bus.pend[2:0], bus.done);
    end
    tick();
    n_checks++;
    if (bus.grant_err !== 1'b1 || bus.request !== 3'b001) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b req=%b expected 1/001", bus.grant_err, bus.request);
    end
    do_reset();
    n_checks++;
    if (bus.grant_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_cleared: got %b expected 0", bus.grant_err);
    end
    bus.grant = 3'b010;
    tick();
    bus.grant = 3'b000;
    n_checks++;
    if (bus.grant_err !== 1'b1 || bus.done !== 3'b000 || bus.pend !== 9'd0) begin
      n_fail++;
      $display("FAIL err_idle_grant: got err=%b done=%b pend=%h expected 1/000/0",
               bus.grant_err, bus.done, bus.pend);
    end
    tick();
    n_checks++;
    if (bus.done !== 3'b000 || bus.request !== 3'b000) begin
      n_fail++;
      $display("FAIL err_idle_after: got done=%b req=%b expected 000/000", bus.done, bus.request);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] gseq [3];
    logic [2:0] dexp [3];
    gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b011;
    dexp[0] = 3'b001; dexp[1] = 3'b010; dexp[2] = 3'b100;
    do_reset();
    bus.push = 3'b111;
    tick();
    bus.push = 3'b000;
    for (int k = 0; k < 3; k++) begin
      bus.grant = gseq[k];
      tick();
      n_checks++;
      if (bus.done !== dexp[k]) begin
        n_fail++;
        $display("FAIL b2b_done grant %0d: got %b expected %b", k, bus.done, dexp[k]);
      end
    end
    bus.grant = 3'b000;
    tick();
    n_checks++;
    if (bus.done !== 3'b000 || bus.pend !== 9'd0 || bus.request !== 3'b000
        || bus.grant_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got done=%b pend=%h req=%b err=%b expected 000/0/000/0",
               bus.done, bus.pend, bus.request, bus.grant_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.push = 3'b111;
    tick();
    tick();
    tick();
    bus.push = 3'b000;
    n_checks++;
    if (bus.pend !== {3'd3, 3'd3, 3'd3} || bus.request !== 3'b111) begin
      n_fail++;
      $display("FAIL midrst_setup: got pend=%h req=%b expected 0db/111", bus.pend, bus.request);
    end
    rst       = 1'b1;
    bus.grant = 3'b001;
    tick();
    rst       = 1'b0;
    bus.grant = 3'b000;
    n_checks++;
    if (bus.request !== 3'b000 || bus.pend !== 9'd0 || bus.done !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_clear: got req=%b pend=%h done=%b expected 000/0/000",
               bus.request, bus.pend, bus.done);
    end
    tick();
    n_checks++;
    if (bus.done !== 3'b000 || bus.request !== 3'b000 || bus.grant_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_after: got done=%b req=%b err=%b expected 000/000/0",
               bus.done, bus.request, bus.grant_err);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.push  = 3'b000;
    bus.grant = 3'b000;
    test_reset();
    test_single();
    test_overflow();
    test_simultaneous();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_req_agent.md
# arb_req_agent

Requester-side agent for the 3-way encoded-grant arbiter. Holds a per-client count of pending transactions for three clients, drives the arbiter's `request[2:0]`, and decodes the arbiter's 3-bit encoded `grant` back into one-hot completion pulses. It also flags any protocol-illegal grant. It sits between the three client engines and the arbiter, one instance per arbitrated resource.

## Interface
- `DEPTH`, default 4: maximum pending transactions per client, range 1..7.
- `CNT_W`, default 3: width of each pending counter; must satisfy 2^CNT_W > DEPTH.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `push`  in  3  bit i: client i enqueues one transaction this cycle.
- `full`  out  3  bit i: client i count == DEPTH. Combinational from state.
- `request`  out  3  bit i: client i requesting. Connects to the arbiter `request`.
- `grant`  in  3  encoding from the arbiter: 000 none, 001 client0, 010 client1, 011 client2, 1xx illegal.
- `done`  out  3  one-hot, registered, one-cycle pulse per accepted grant.
- `pend`  out  3*CNT_W  packed counts; client i at `[i*CNT_W +: CNT_W]`.
- `grant_err`  out  1  sticky protocol-error flag; cleared only by `rst`.

## Operation
- Each client has a counter `cnt_i` and a 3-state FSM: IDLE, REQ, GAP.
- `request[i]` is 1 only while in REQ. It is decoded from the state register, so it is glitch-free.

**Push and grant accounting**
- A push is accepted iff `cnt_i < DEPTH`, evaluated on the pre-edge count.
- A push while full is dropped silently. This holds even if a grant frees a slot in the same cycle.
- A grant is valid for client i iff `grant` decodes to i and the FSM is in REQ.
- Counter update: `cnt_i <= cnt_i + accepted_push - valid_grant`. Simultaneous accepted push and valid grant leave the count unchanged.
- Count can never underflow, because REQ implies `cnt_i >= 1`.

**FSM transitions (per client, evaluated at the edge)**
- IDLE → REQ when an accepted push occurs; otherwise stay in IDLE.
- REQ on a valid grant:
  - with the gap feature: → GAP;
  - without it: → REQ if the post-update count > 0, else → IDLE.
- REQ with no grant: stay in REQ.
- GAP → REQ if the post-update count > 0, else → IDLE. GAP always lasts exactly 1 cycle.

**Completion and errors**
- `done[i]` is registered at the same edge as a valid grant: a one-cycle pulse at most once per grant.
- `grant_err` sets on any of:
  - `grant` = 1xx;
  - `grant` decodes to a client not in REQ.
- An erroneous grant changes no counter, FSM, or `done`.
- `grant` = 000 is always legal.

**Reset**
- `rst` asserted mid-operation discards all pending counts; no `done` pulses are produced for the discarded transactions.

## Timing
- Reset values: every `cnt` 0, every FSM IDLE, `request` 000, `done` 000, `full` 000, `pend` 0, `grant_err` 0.
- Push at edge t → `request[i]` high in cycle t+1, and `pend` reflects the new count in cycle t+1.
- Valid grant sampled at edge t → `done[i]` high during cycle t+1 only. The count decrements at edge t.
- With the gap feature, after a grant `request[i]` is low for exactly cycle t+1 and can reassert in cycle t+2.
- Without the gap feature, `request[i]` stays high continuously while the count is ≥ 1.
- The arbiter may grant one client per cycle; back-to-back grants to different clients are legal and each produces its own `done` pulse.

## Configuration
- Macro: `ARB_REQ_GAP_EN`.
- Defined: the GAP state is compiled in. Every grant forces a one-cycle request deassertion, so the arbiter observes a request edge per transaction.
- Undefined: the GAP state is removed and REQ transitions directly as described in Operation; `request` may stay high for DEPTH consecutive grants.
- Counters, error detection and `done` behave identically in both builds.

## Test plan
- Reset then idle: with `rst`=1 for 2 cycles, then `push`=000 and `grant`=000 for 10 cycles → `request`=000, `done`=000, `pend`=0, `grant_err`=0 throughout.
- Single transaction: `push`=001 at edge 1; `grant`=001 sampled at edge 3 → `request[0]` high in cycles 2–3, `done`=001 in cycle 4 only, `pend0` returns to 0. With the gap feature, the FSM goes GAP then IDLE.
- Overflow: `push[1]`=1 for 6 consecutive cycles with DEPTH=4 and no grants → `pend1`=4 and `full[1]`=1; pushes 5 and 6 are dropped. A subsequent grant 010 reduces the count to 3.
- Simultaneous push and grant: `cnt2`=2; in one cycle `push`=100 and `grant`=011 → `cnt2` stays 2, `done[2]` pulses once, `request[2]` follows the configured GAP rule.
- Protocol errors: `grant`=101 → `grant_err`=1, counts unchanged. After reset, `grant`=010 while client1 is IDLE → `grant_err`=1 and no `done` pulse.
- Reset mid-operation: all counts at 3, then `rst` pulses for 1 cycle → next cycle `request`=000 and `pend`=0. No `done` pulse follows, even if `grant`=001 was present during the reset cycle.
